// File: rtl/wb_pkg.sv
// Shared sizing and requester encoding for the writeback arbiter slice.
package wb_pkg;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int IDX_W = $clog2(NREG);

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_e;
endpackage

// File: rtl/wb_arbiter_if.sv
// Issue, writeback-channel, register-file write and bypass signals of wb_arbiter.
interface wb_arbiter_if #(
    parameter int XLEN = wb_pkg::XLEN,
    parameter int NREG = wb_pkg::NREG
);
    localparam int IW = $clog2(NREG);

    logic            issue_valid;
    logic [IW-1:0]   issue_rd;
    logic [IW-1:0]   issue_rs1;
    logic [IW-1:0]   issue_rs2;
    logic            issue_stall;

    logic            alu_valid;
    logic [IW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            lsu_valid;
    logic [IW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;

    logic            w_enable;
    logic [IW-1:0]   rd_num;
    logic [XLEN-1:0] rd_data;

    logic            byp_rs1_hit;
    logic            byp_rs2_hit;
    logic [XLEN-1:0] byp_data;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  issue_stall, alu_ready, lsu_ready,
        input  w_enable, rd_num, rd_data,
        input  byp_rs1_hit, byp_rs2_hit, byp_data
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output issue_stall, alu_ready, lsu_ready,
        output w_enable, rd_num, rd_data,
        output byp_rs1_hit, byp_rs2_hit, byp_data
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last-grant pointer only moves on a granted beat.
module rr_arb2
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    req_e last;
    req_e win;

    always_comb begin
        gnt = '0;
        win = last;
        if (rst_n) begin
            if (req[REQ_ALU] && req[REQ_LSU])
                win = (last == REQ_ALU) ? REQ_LSU : REQ_ALU;
            else if (req[REQ_ALU])
                win = REQ_ALU;
            else
                win = REQ_LSU;
            if (|req)
                gnt[win] = 1'b1;
        end
    end

    // Reset to LSU so the ALU takes the first conflict.
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= REQ_LSU;
        else if (|gnt)
            last <= win;
    end
endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter with register scoreboard; define WB_BYPASS_EN to forward write-stage data
// to the issue stage instead of stalling on it.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN = wb_pkg::XLEN,
    parameter int NREG = wb_pkg::NREG
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);
    localparam int IW = $clog2(NREG);

    logic [1:0]      req;
    logic [1:0]      gnt;
    logic            beat_acc;
    logic [IW-1:0]   beat_rd;
    logic [XLEN-1:0] beat_data;

    logic            w_en_q;
    logic [IW-1:0]   rd_num_q;
    logic [XLEN-1:0] rd_data_q;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            byp1;
    logic            byp2;
    logic            stall;

    assign req[REQ_ALU] = bus.alu_valid;
    assign req[REQ_LSU] = bus.lsu_valid;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt)
    );

    assign bus.alu_ready = gnt[REQ_ALU];
    assign bus.lsu_ready = gnt[REQ_LSU];
    assign beat_acc      = |gnt;
    assign beat_rd       = gnt[REQ_LSU] ? bus.lsu_rd   : bus.alu_rd;
    assign beat_data     = gnt[REQ_LSU] ? bus.lsu_data : bus.alu_data;

    // rd 0 beats are consumed but never reach the register file.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_en_q    <= 1'b0;
            rd_num_q  <= '0;
            rd_data_q <= '0;
        end else begin
            w_en_q <= beat_acc && (beat_rd != '0);
            if (beat_acc) begin
                rd_num_q  <= beat_rd;
                rd_data_q <= beat_data;
            end
        end
    end

    assign bus.w_enable = w_en_q;
    assign bus.rd_num   = rd_num_q;
    assign bus.rd_data  = rd_data_q;

`ifdef WB_BYPASS_EN
    assign byp1 = w_en_q && (bus.issue_rs1 != '0) && (rd_num_q == bus.issue_rs1);
    assign byp2 = w_en_q && (bus.issue_rs2 != '0) && (rd_num_q == bus.issue_rs2);
    assign bus.byp_data = rd_data_q;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
    assign bus.byp_data = '0;
`endif
    assign bus.byp_rs1_hit = byp1;
    assign bus.byp_rs2_hit = byp2;

    // busy[0] is held at 0, so register 0 never contributes a hazard.
    assign stall = bus.issue_valid &&
                   ((busy[bus.issue_rs1] && !byp1) ||
                    (busy[bus.issue_rs2] && !byp2) ||
                    busy[bus.issue_rd]);
    assign bus.issue_stall = stall;

    // Clear first so a same-cycle issue to the written register keeps it busy.
    always_comb begin
        busy_nxt = busy;
        if (w_en_q)
            busy_nxt[rd_num_q] = 1'b0;
        if (bus.issue_valid && !stall && (bus.issue_rd != '0))
            busy_nxt[bus.issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL provide parameter XLEN, default 32, meaning the data width.
REQ-002 SHALL provide parameter NREG, default 32, meaning the number of architectural registers, with index width $clog2(NREG).
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL provide issue_valid (in, 1), issue_rd (in, 5), issue_rs1 (in, 5) and issue_rs2 (in, 5): decoder issue request with destination and source registers.
REQ-006 SHALL provide issue_stall, output, 1 bit: the issue is blocked by a hazard.
REQ-007 SHALL provide alu_valid (in, 1), alu_rd (in, 5), alu_data (in, XLEN) and alu_ready (out, 1): ALU writeback channel.
REQ-008 SHALL provide lsu_valid (in, 1), lsu_rd (in, 5), lsu_data (in, XLEN) and lsu_ready (out, 1): load-unit writeback channel.
REQ-009 SHALL provide w_enable (out, 1), rd_num (out, 5) and rd_data (out, XLEN): the register-file write port.
REQ-010 SHALL provide byp_rs1_hit (out, 1), byp_rs2_hit (out, 1) and byp_data (out, XLEN): forwarding of the write-stage data.

Function
REQ-011 SHALL accept a writeback beat when valid and ready are both high; a requester holds valid, rd and data stable until accepted.
REQ-012 SHALL make ready combinational from both valids: the sole valid requester wins; on a conflict the requester not granted last time wins.
REQ-013 SHALL update the last-grant register only on an accepted beat.
REQ-014 SHALL register an accepted beat into the write stage: w_enable, rd_num and rd_data appear exactly 1 cycle after acceptance.
REQ-015 SHALL accept a beat with rd equal to 0 but drive w_enable 0 in the following cycle.
REQ-016 SHALL keep a busy bit per register 1..NREG-1; busy[0] is constantly 0.
REQ-017 SHALL assert issue_stall when issue_valid is high and busy is set for rs1, rs2 or rd, with register 0 excluded.
REQ-018 SHALL set busy[issue_rd] on an issue that is valid, not stalled and has a nonzero rd.
REQ-019 SHALL clear busy[rd_num] in the cycle w_enable is high, with the change visible the next cycle.
REQ-020 SHALL let set win over clear when an issue and a write target the same rd in the same cycle.
REQ-021 SHALL keep a beat whose rd is not busy (spurious) writable, with no change to busy.
REQ-022 SHALL never let w_enable be high without exactly one beat having been accepted in the prior cycle.

Reset
REQ-023 SHALL, while rst_n is low at a clock edge, clear all busy bits, w_enable, rd_num and rd_data to 0, and set last-grant to LSU so the ALU wins the first conflict.
REQ-024 SHALL force alu_ready and lsu_ready to 0 while rst_n is low; a write-stage beat pending when reset is asserted is discarded.

Configuration
REQ-025 SHALL, with WB_BYPASS_EN defined, exclude rs1/rs2 from the stall when busy is set only because w_enable is high with rd_num matching, assert byp_rs1_hit/byp_rs2_hit and drive byp_data equal to rd_data.
REQ-026 SHALL, without WB_BYPASS_EN, tie byp_rs1_hit, byp_rs2_hit and byp_data to 0 and stall on every busy source register.

Structure
REQ-027 SHALL place XLEN, NREG, the register-index width and the requester enum (REQ_ALU, REQ_LSU) in the shared package wb_pkg.
REQ-028 SHALL implement the two-way round-robin grant as a sub-module rr_arb2.

Verification
REQ-029 SHALL cover: issue rd=5 -> busy[5] set; ALU beat rd=5, data 0xDEADBEEF -> next cycle w_enable=1, rd_num=5, rd_data=0xDEADBEEF; busy[5] clear after.
REQ-030 SHALL cover: ALU and LSU both valid for 3 cycles after reset -> grants ALU, LSU, ALU.
REQ-031 SHALL cover: busy[7] set, issue rs1=7 -> issue_stall=1; with WB_BYPASS_EN and the write of 7 in the write stage -> stall=0, byp_rs1_hit=1.
REQ-032 SHALL cover: issue rd=3 and write of rd=3 in the same cycle -> busy[3] remains 1.
REQ-033 SHALL cover: LSU beat rd=0 -> lsu_ready=1, next cycle w_enable=0; issue rs1=0 never stalls.
REQ-034 SHALL cover: rst_n low mid-burst with ALU valid -> alu_ready=0, w_enable=0 next cycle, all busy bits 0.
